// File: rtl/bip_debug_unit_if.sv
// UART, program-memory and CPU-control signals seen by the BIP debug unit.
// The master side is the debug unit; the slave side is its environment.
interface bip_debug_unit_if #(
    parameter int unsigned PM_ADDR_W = 11,
    parameter int unsigned DATA_W    = 16
);
    logic [7:0]           RX_DATA;
    logic                 RX_VALID;
    logic [7:0]           TX_DATA;
    logic                 TX_START;
    logic                 TX_BUSY;
    logic                 PM_WE;
    logic [PM_ADDR_W-1:0] PM_WADDR;
    logic [DATA_W-1:0]    PM_WDATA;
    logic                 CPU_RESET;
    logic                 CPU_EN;
    logic [DATA_W-1:0]    CPU_INSTRUCTION;
    logic [PM_ADDR_W-1:0] CPU_PC;
    logic [DATA_W-1:0]    CPU_ACC;
    logic                 HALTED;

    modport master (
        input  RX_DATA, RX_VALID, TX_BUSY, CPU_INSTRUCTION, CPU_PC, CPU_ACC,
        output TX_DATA, TX_START, PM_WE, PM_WADDR, PM_WDATA, CPU_RESET, CPU_EN, HALTED
    );

    modport slave (
        output RX_DATA, RX_VALID, TX_BUSY, CPU_INSTRUCTION, CPU_PC, CPU_ACC,
        input  TX_DATA, TX_START, PM_WE, PM_WADDR, PM_WDATA, CPU_RESET, CPU_EN, HALTED
    );
endinterface

// File: rtl/bip_debug_unit.sv
// BIP run/debug sequencer: UART byte commands load program memory, run or
// single-step the CPU, and each run/step ends with a 7-byte status report.
module bip_debug_unit #(
    parameter int unsigned PM_ADDR_W  = 11,
    parameter int unsigned DATA_W     = 16,
    parameter logic [15:0] MAX_CYCLES = 16'hFFFF
) (
    input  logic             CLK,
    input  logic             RESET,
    bip_debug_unit_if.master bus
);
    localparam int unsigned CNT_W     = 16;
    localparam int unsigned OPC_W     = 5;
    localparam logic [7:0]  CMD_LOAD  = 8'h4C;
    localparam logic [7:0]  CMD_RUN   = 8'h52;
    localparam logic [7:0]  CMD_STEP  = 8'h53;
    localparam logic [2:0]  RPT_BYTES = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_N, S_LOAD_HI, S_LOAD_LO, S_RUN_RST, S_RUN, S_STEP, S_REPORT
    } state_e;

    state_e               state_q, state_d;
    logic [7:0]           n_q, n_d;
    logic [PM_ADDR_W-1:0] idx_q, idx_d;
    logic [7:0]           hi_q, hi_d;
    logic                 pm_we_q, pm_we_d;
    logic [PM_ADDR_W-1:0] pm_waddr_q, pm_waddr_d;
    logic [DATA_W-1:0]    pm_wdata_q, pm_wdata_d;
    logic                 cpu_reset_q, cpu_reset_d;
    logic                 halted_q, halted_d;
    logic                 timeout_q, timeout_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 tx_start_q, tx_start_d;
    logic [7:0]           tx_data_q, tx_data_d;
    logic [2:0]           byte_q, byte_d;
    logic [1:0]           gap_q, gap_d;
    logic [DATA_W-1:0]    acc_q, acc_d;
    logic [PM_ADDR_W-1:0] pc_q, pc_d;
    logic                 cpu_en_c;
    logic                 halt_c;
    logic [15:0]          acc16_c;
    logic [15:0]          pc16_c;
    logic [7:0]           rpt_byte_c;

    assign halt_c  = (bus.CPU_INSTRUCTION[DATA_W-1 -: OPC_W] == 5'b00000);
    assign acc16_c = 16'(acc_q);
    assign pc16_c  = 16'(pc_q);

    // Report byte selected by how many bytes have already been issued.
    always_comb begin
        rpt_byte_c = 8'h00;
        case (byte_q)
            3'd0:    rpt_byte_c = {6'b0, timeout_q, halted_q};
            3'd1:    rpt_byte_c = acc16_c[15:8];
            3'd2:    rpt_byte_c = acc16_c[7:0];
            3'd3:    rpt_byte_c = pc16_c[15:8];
            3'd4:    rpt_byte_c = pc16_c[7:0];
            3'd5:    rpt_byte_c = cnt_q[15:8];
            3'd6:    rpt_byte_c = cnt_q[7:0];
            default: rpt_byte_c = 8'h00;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q     <= S_IDLE;
            n_q         <= '0;
            idx_q       <= '0;
            hi_q        <= '0;
            pm_we_q     <= 1'b0;
            pm_waddr_q  <= '0;
            pm_wdata_q  <= '0;
            cpu_reset_q <= 1'b1;
            halted_q    <= 1'b0;
            timeout_q   <= 1'b0;
            cnt_q       <= '0;
            tx_start_q  <= 1'b0;
            tx_data_q   <= '0;
            byte_q      <= '0;
            gap_q       <= '0;
            acc_q       <= '0;
            pc_q        <= '0;
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            idx_q       <= idx_d;
            hi_q        <= hi_d;
            pm_we_q     <= pm_we_d;
            pm_waddr_q  <= pm_waddr_d;
            pm_wdata_q  <= pm_wdata_d;
            cpu_reset_q <= cpu_reset_d;
            halted_q    <= halted_d;
            timeout_q   <= timeout_d;
            cnt_q       <= cnt_d;
            tx_start_q  <= tx_start_d;
            tx_data_q   <= tx_data_d;
            byte_q      <= byte_d;
            gap_q       <= gap_d;
            acc_q       <= acc_d;
            pc_q        <= pc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (bus.RX_VALID) begin
                    if (bus.RX_DATA == CMD_LOAD)      state_d = S_LOAD_N;
                    else if (bus.RX_DATA == CMD_RUN)  state_d = S_RUN_RST;
                    else if (bus.RX_DATA == CMD_STEP) state_d = S_STEP;
                end
            end
            S_LOAD_N:  if (bus.RX_VALID) state_d = (bus.RX_DATA == 8'h00) ? S_IDLE : S_LOAD_HI;
            S_LOAD_HI: if (bus.RX_VALID) state_d = S_LOAD_LO;
            S_LOAD_LO: begin
                if (bus.RX_VALID)
                    state_d = ((idx_q + PM_ADDR_W'(1)) == PM_ADDR_W'(n_q)) ? S_IDLE : S_LOAD_HI;
            end
            S_RUN_RST: state_d = S_RUN;
            S_RUN:     if (halt_c || (cnt_q == MAX_CYCLES)) state_d = S_REPORT;
            S_STEP:    state_d = S_REPORT;
            // Leave once the last byte's post-start ignore cycle has elapsed.
            S_REPORT:  if ((byte_q == RPT_BYTES) && (gap_q == 2'd1)) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        n_d         = n_q;
        idx_d       = idx_q;
        hi_d        = hi_q;
        pm_we_d     = 1'b0;
        pm_waddr_d  = pm_waddr_q;
        pm_wdata_d  = pm_wdata_q;
        cpu_reset_d = 1'b0;
        cpu_en_c    = 1'b0;
        halted_d    = halted_q;
        timeout_d   = timeout_q;
        cnt_d       = cnt_q;
        tx_start_d  = 1'b0;
        tx_data_d   = tx_data_q;
        byte_d      = byte_q;
        gap_d       = gap_q;
        acc_d       = acc_q;
        pc_d        = pc_q;
        case (state_q)
            S_IDLE: begin
                if (bus.RX_VALID && (bus.RX_DATA == CMD_RUN)) cpu_reset_d = 1'b1;
            end
            S_LOAD_N: begin
                if (bus.RX_VALID) begin
                    n_d   = bus.RX_DATA;
                    idx_d = '0;
                end
            end
            S_LOAD_HI: if (bus.RX_VALID) hi_d = bus.RX_DATA;
            S_LOAD_LO: begin
                if (bus.RX_VALID) begin
                    pm_we_d    = 1'b1;
                    pm_waddr_d = idx_q;
                    pm_wdata_d = DATA_W'({hi_q, bus.RX_DATA});
                    idx_d      = idx_q + PM_ADDR_W'(1);
                end
            end
            S_RUN_RST: begin
                cnt_d     = '0;
                timeout_d = 1'b0;
                halted_d  = 1'b0;
            end
            // CPU_EN is combinational so the HALT word is caught before it executes.
            S_RUN: begin
                byte_d = '0;
                gap_d  = '0;
                if (halt_c) begin
                    halted_d = 1'b1;
                end else if (cnt_q == MAX_CYCLES) begin
                    timeout_d = 1'b1;
                end else begin
                    cpu_en_c = RESET;
                    cnt_d    = cnt_q + CNT_W'(1);
                end
            end
            S_STEP: begin
                byte_d = '0;
                gap_d  = '0;
                if (halt_c) begin
                    halted_d = 1'b1;
                end else begin
                    cpu_en_c = RESET;
                    halted_d = 1'b0;
                    if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
                end
            end
            // ACC/PC track the frozen CPU until the first byte goes out.
            S_REPORT: begin
                if ((byte_q == 3'd0) && (gap_q == 2'd0)) begin
                    acc_d = bus.CPU_ACC;
                    pc_d  = bus.CPU_PC;
                end
                if (gap_q != 2'd0) begin
                    gap_d = gap_q - 2'd1;
                end else if ((byte_q != RPT_BYTES) && !bus.TX_BUSY) begin
                    tx_start_d = 1'b1;
                    tx_data_d  = rpt_byte_c;
                    byte_d     = byte_q + 3'd1;
                    gap_d      = 2'd2;
                end
            end
            default: ;
        endcase
    end

    assign bus.TX_DATA   = tx_data_q;
    assign bus.TX_START  = tx_start_q;
    assign bus.PM_WE     = pm_we_q;
    assign bus.PM_WADDR  = pm_waddr_q;
    assign bus.PM_WDATA  = pm_wdata_q;
    assign bus.CPU_RESET = cpu_reset_q;
    assign bus.CPU_EN    = cpu_en_c;
    assign bus.HALTED    = halted_q;
endmodule
